// File: rtl/seg_scroll_ctrl.sv
// seg_scroll_ctrl: scroll sequencer for the four-digit segment display window bus.
// An 8-digit BCD number is loaded into a 10-entry nibble ring. The ring holds the
// 8 digits followed by 2 blank gap digits. A 4-digit window is rotated across the
// ring once every STEP_DIV cycles of the 190 Hz scan clock.
// Optional feature macro: SCROLL_BCD_CHECK_EN. When it is defined, illegal digits
// (>9) are replaced by the 4'hA error glyph and the sticky bcd_err flag is raised.
module seg_scroll_ctrl #(
    parameter int unsigned STEP_DIV   = 95,
    parameter logic [3:0]  BLANK_CODE = 4'hB
) (
    input  logic        clk190hz,
    input  logic        reset,
    input  logic [31:0] number_in,
    input  logic        load,
    input  logic        start,
    input  logic        stop,
    input  logic        pause,
    input  logic        dir,
    output logic [15:0] data_bus,
    output logic        busy,
    output logic        step_pulse,
    output logic        wrap_pulse,
    output logic [3:0]  lap_cnt,
    output logic [1:0]  state_out,
    output logic        bcd_err
);

    localparam int unsigned RING_N = 10;
    localparam int unsigned DIV_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        HOLD   = 2'b01,
        SCROLL = 2'b10,
        PAUSED = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       ring_q [RING_N];
    logic [3:0]       ring_d [RING_N];
    logic [3:0]       head_q, head_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [15:0]      data_bus_q, data_bus_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;
    logic [3:0]       lap_q, lap_d;
    logic [3:0]       load_dig [8];
`ifdef SCROLL_BCD_CHECK_EN
    logic             bcd_err_q, bcd_err_d;
    logic             load_bad;
`endif

    // Ring index (head + offset) reduced modulo 10.
    function automatic logic [3:0] ring_idx(input logic [3:0] h, input logic [1:0] off);
        logic [4:0] s;
        s = {1'b0, h} + {3'b000, off};
        if (s >= 5'd10) begin
            s = s - 5'd10;
        end
        return s[3:0];
    endfunction

    // Head after one step to the left (+1) or right (-1), modulo 10.
    function automatic logic [3:0] step_head(input logic [3:0] h, input logic d);
        logic [3:0] n;
        if (!d) begin
            n = (h == 4'd9) ? 4'd0 : h + 4'd1;
        end else begin
            n = (h == 4'd0) ? 4'd9 : h - 4'd1;
        end
        return n;
    endfunction

    // A step wraps the ring when it goes 9->0 (left) or 0->9 (right).
    function automatic logic step_wraps(input logic [3:0] h, input logic d);
        return d ? (h == 4'd0) : (h == 4'd9);
    endfunction

    // Split the incoming number into digits, leftmost first, screening illegal codes when enabled.
    always_comb begin
`ifdef SCROLL_BCD_CHECK_EN
        load_bad = 1'b0;
`endif
        for (int i = 0; i < 8; i++) begin
            load_dig[i] = number_in[31-4*i -: 4];
`ifdef SCROLL_BCD_CHECK_EN
            if (load_dig[i] > 4'd9) begin
                load_dig[i] = 4'hA;
                load_bad    = 1'b1;
            end
`endif
        end
    end

    // Next-state logic: load overrides everything, then stop, pause, start.
    always_comb begin
        state_d   = state_q;
        ring_d    = ring_q;
        head_d    = head_q;
        div_cnt_d = div_cnt_q;
        lap_d     = lap_q;
        step_d    = 1'b0;
        wrap_d    = 1'b0;
`ifdef SCROLL_BCD_CHECK_EN
        bcd_err_d = bcd_err_q;
`endif

        if (load) begin
            for (int i = 0; i < 8; i++) begin
                ring_d[i] = load_dig[i];
            end
            ring_d[8] = BLANK_CODE;
            ring_d[9] = BLANK_CODE;
            head_d    = 4'd0;
            div_cnt_d = '0;
            lap_d     = 4'd0;
            state_d   = HOLD;
`ifdef SCROLL_BCD_CHECK_EN
            bcd_err_d = load_bad;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    // Nothing to show until a number has been loaded.
                end
                HOLD: begin
                    if (!stop && !pause && start) begin
                        state_d   = SCROLL;
                        div_cnt_d = '0;
                    end
                end
                SCROLL: begin
                    if (stop) begin
                        state_d   = HOLD;
                        div_cnt_d = '0;
                    end else if (pause) begin
                        // Divider count is kept so the step phase survives the pause.
                        state_d = PAUSED;
                    end else if (div_cnt_q == DIV_LAST) begin
                        div_cnt_d = '0;
                        head_d    = step_head(head_q, dir);
                        step_d    = 1'b1;
                        if (step_wraps(head_q, dir)) begin
                            wrap_d = 1'b1;
                            lap_d  = lap_q + 4'd1;
                        end
                    end else begin
                        div_cnt_d = div_cnt_q + DIV_W'(1);
                    end
                end
                PAUSED: begin
                    if (stop) begin
                        state_d   = HOLD;
                        div_cnt_d = '0;
                    end else if (!pause) begin
                        state_d = SCROLL;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Window is built from the next-state ring and head so the bus tracks them with no extra lag.
    always_comb begin
        data_bus_d = {ring_d[ring_idx(head_d, 2'd0)],
                      ring_d[ring_idx(head_d, 2'd1)],
                      ring_d[ring_idx(head_d, 2'd2)],
                      ring_d[ring_idx(head_d, 2'd3)]};
    end

    // State, ring and output registers with synchronous reset.
    always_ff @(posedge clk190hz) begin
        if (reset) begin
            state_q    <= IDLE;
            for (int i = 0; i < RING_N; i++) begin
                ring_q[i] <= BLANK_CODE;
            end
            head_q     <= 4'd0;
            div_cnt_q  <= '0;
            data_bus_q <= {4{BLANK_CODE}};
            step_q     <= 1'b0;
            wrap_q     <= 1'b0;
            lap_q      <= 4'd0;
        end else begin
            state_q    <= state_d;
            ring_q     <= ring_d;
            head_q     <= head_d;
            div_cnt_q  <= div_cnt_d;
            data_bus_q <= data_bus_d;
            step_q     <= step_d;
            wrap_q     <= wrap_d;
            lap_q      <= lap_d;
        end
    end

`ifdef SCROLL_BCD_CHECK_EN
    // Sticky illegal-digit flag, refreshed only by a load.
    always_ff @(posedge clk190hz) begin
        if (reset) begin
            bcd_err_q <= 1'b0;
        end else begin
            bcd_err_q <= bcd_err_d;
        end
    end

    assign bcd_err = bcd_err_q;
`else
    assign bcd_err = 1'b0;
`endif

    assign data_bus   = data_bus_q;
    assign busy       = (state_q == SCROLL) || (state_q == PAUSED);
    assign step_pulse = step_q;
    assign wrap_pulse = wrap_q;
    assign lap_cnt    = lap_q;
    assign state_out  = state_q;

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// Directed bench for seg_scroll_ctrl with a 4-cycle step divider.
module tb_seg_scroll_ctrl;

    logic        clk190hz;
    logic        reset;
    logic [31:0] number_in;
    logic        load;
    logic        start;
    logic        stop;
    logic        pause;
    logic        dir;
    logic [15:0] data_bus;
    logic        busy;
    logic        step_pulse;
    logic        wrap_pulse;
    logic [3:0]  lap_cnt;
    logic [1:0]  state_out;
    logic        bcd_err;

    int n_tests;
    int n_fail;
    int step_seen;
    logic [15:0] exp_win [10];

    seg_scroll_ctrl #(
        .STEP_DIV   (4),
        .BLANK_CODE (4'hB)
    ) dut (
        .clk190hz   (clk190hz),
        .reset      (reset),
        .number_in  (number_in),
        .load       (load),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .dir        (dir),
        .data_bus   (data_bus),
        .busy       (busy),
        .step_pulse (step_pulse),
        .wrap_pulse (wrap_pulse),
        .lap_cnt    (lap_cnt),
        .state_out  (state_out),
        .bcd_err    (bcd_err)
    );

    initial clk190hz = 1'b0;
    always #5 clk190hz = ~clk190hz;

    task automatic tick();
        @(posedge clk190hz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        number_in = 32'h0;
        load      = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        pause     = 1'b0;
        dir       = 1'b0;
        exp_win   = '{16'h1235, 16'h2356, 16'h3567, 16'h5678, 16'h678B,
                      16'h78BB, 16'h8BB4, 16'hBB41, 16'hB412, 16'h4123};

        // Reset values
        tick();
        tick();
        chk("rst_bus",   data_bus,   16'hBBBB);
        chk("rst_state", state_out,  2'b00);
        chk("rst_busy",  busy,       1'b0);
        chk("rst_step",  step_pulse, 1'b0);
        chk("rst_wrap",  wrap_pulse, 1'b0);
        chk("rst_lap",   lap_cnt,    4'd0);
        chk("rst_err",   bcd_err,    1'b0);
        reset = 1'b0;

        // IDLE ignores start
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("idle_start_state", state_out, 2'b00);
        chk("idle_start_bus",   data_bus,  16'hBBBB);

        // Test 1: load
        number_in = 32'h4123_5678;
        load      = 1'b1;
        tick();
        load = 1'b0;
        chk("t1_bus",   data_bus,  16'h4123);
        chk("t1_state", state_out, 2'b01);
        chk("t1_busy",  busy,      1'b0);

        // Test 2: scroll left through a full lap
        start = 1'b1;
        dir   = 1'b0;
        tick();
        start = 1'b0;
        chk("t2_state", state_out, 2'b10);
        chk("t2_busy",  busy,      1'b1);
        for (int k = 0; k < 10; k++) begin
            step_seen = 0;
            for (int c = 0; c < 3; c++) begin
                tick();
                if (step_pulse === 1'b1) step_seen++;
            end
            chk($sformatf("t2_gap%0d", k), step_seen, 0);
            tick();
            chk($sformatf("t2_step%0d", k), step_pulse, 1'b1);
            chk($sformatf("t2_bus%0d", k),  data_bus,   exp_win[k]);
            chk($sformatf("t2_wrap%0d", k), wrap_pulse, (k == 9) ? 1'b1 : 1'b0);
        end
        chk("t2_lap", lap_cnt, 4'd1);
        tick();
        chk("t2_step_clear", step_pulse, 1'b0);
        chk("t2_wrap_clear", wrap_pulse, 1'b0);

        // Test 3: stop to HOLD keeping head=0, then scroll right
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t3_hold_state", state_out, 2'b01);
        chk("t3_hold_bus",   data_bus,  16'h4123);
        chk("t3_hold_busy",  busy,      1'b0);
        start = 1'b1;
        dir   = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("t3_pre_step", step_pulse, 1'b0);
        tick();
        chk("t3_step", step_pulse, 1'b1);
        chk("t3_bus",  data_bus,   16'hB412);
        chk("t3_wrap", wrap_pulse, 1'b1);
        chk("t3_lap",  lap_cnt,    4'd2);

        // Test 4: pause at div_cnt=2 for 20 cycles
        tick();
        tick();
        pause     = 1'b1;
        step_seen = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (step_pulse === 1'b1) step_seen++;
        end
        chk("t4_no_step", step_seen, 0);
        chk("t4_state",   state_out, 2'b11);
        chk("t4_bus",     data_bus,  16'hB412);
        chk("t4_busy",    busy,      1'b1);
        pause = 1'b0;
        tick();
        chk("t4_resume_state", state_out,  2'b10);
        chk("t4_resume_step0", step_pulse, 1'b0);
        tick();
        chk("t4_resume_step1", step_pulse, 1'b0);
        tick();
        chk("t4_resume_step2", step_pulse, 1'b1);
        chk("t4_resume_bus",   data_bus,   16'hBB41);
        chk("t4_resume_wrap",  wrap_pulse, 1'b0);

        // Test 5: load and pause together while scrolling
        tick();
        number_in = 32'h8765_4321;
        load      = 1'b1;
        pause     = 1'b1;
        tick();
        load  = 1'b0;
        pause = 1'b0;
        chk("t5_state", state_out, 2'b01);
        chk("t5_bus",   data_bus,  16'h8765);
        chk("t5_lap",   lap_cnt,   4'd0);

        // Stop on the terminal-count cycle suppresses the step
        start = 1'b1;
        dir   = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("tc_stop_step",  step_pulse, 1'b0);
        chk("tc_stop_state", state_out,  2'b01);
        chk("tc_stop_bus",   data_bus,   16'h8765);

        // Test 6: illegal digits
        number_in = 32'h12AF_3456;
        load      = 1'b1;
        tick();
        load = 1'b0;
`ifdef SCROLL_BCD_CHECK_EN
        chk("t6_bus", data_bus, 16'h12AA);
        chk("t6_err", bcd_err,  1'b1);
        tick();
        chk("t6_err_sticky", bcd_err, 1'b1);
`else
        chk("t6_bus", data_bus, 16'h12AF);
        chk("t6_err", bcd_err,  1'b0);
`endif
        number_in = 32'h1111_2222;
        load      = 1'b1;
        tick();
        load = 1'b0;
        chk("t6_clean_bus", data_bus, 16'h1111);
        chk("t6_clean_err", bcd_err,  1'b0);

        // Reset in the middle of scrolling
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk("midrst_pre_busy", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_bus",   data_bus,  16'hBBBB);
        chk("midrst_state", state_out, 2'b00);
        chk("midrst_busy",  busy,      1'b0);
        chk("midrst_lap",   lap_cnt,   4'd0);
        chk("midrst_step",  step_pulse, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
